// File: rtl/vga_scan_ctrl_pkg.sv
// Shared raster geometry, counter width and frame-phase encoding for the VGA scan controller.
package vga_scan_ctrl_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned VGA_H_VIS  = 640;
  localparam int unsigned VGA_H_FP   = 16;
  localparam int unsigned VGA_H_SYNC = 96;
  localparam int unsigned VGA_H_BP   = 48;
  localparam int unsigned VGA_H_TOT  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_VIS  = 480;
  localparam int unsigned VGA_V_FP   = 10;
  localparam int unsigned VGA_V_SYNC = 2;
  localparam int unsigned VGA_V_BP   = 33;
  localparam int unsigned VGA_V_TOT  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic {
    PH_ACTIVE = 1'b0,
    PH_VBLANK = 1'b1
  } phase_e;

  // Half-open range test [lo, hi) on raster coordinates.
  function automatic logic in_span(input logic [CNT_W-1:0] x,
                                   input logic [CNT_W-1:0] lo,
                                   input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_timing.sv
// Pixel-rate divider, horizontal/vertical raster counters and registered sync outputs.
module vga_scan_ctrl_timing
  import vga_scan_ctrl_pkg::*;
#(
  parameter int unsigned H_VIS  = VGA_H_VIS,
  parameter int unsigned H_FP   = VGA_H_FP,
  parameter int unsigned H_SYNC = VGA_H_SYNC,
  parameter int unsigned H_BP   = VGA_H_BP,
  parameter int unsigned V_VIS  = VGA_V_VIS,
  parameter int unsigned V_FP   = VGA_V_FP,
  parameter int unsigned V_SYNC = VGA_V_SYNC,
  parameter int unsigned V_BP   = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pixpulse_o,
  output logic [CNT_W-1:0] hcount_o,
  output logic [CNT_W-1:0] vcount_o,
  output logic             hsync_o,
  output logic             vsync_o
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_VIS + H_FP);
  localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_VIS + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_VIS + V_FP);
  localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_VIS + V_FP + V_SYNC);

  logic [1:0]       div_q;
  logic             pix_q;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic             hs_q, vs_q;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // pix_q is registered from div_q==2 so it is high exactly while div_q==3.
  // Syncs are decoded from the next counter values so they line up with hcount/vcount.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 2'd0;
      pix_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      div_q <= div_q + 2'd1;
      pix_q <= (div_q == 2'd2);
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= ~in_span(h_d, H_SS, H_SE);
      vs_q  <= ~in_span(v_d, V_SS, V_SE);
    end
  end

  assign pixpulse_o = pix_q;
  assign hcount_o   = h_q;
  assign vcount_o   = v_q;
  assign hsync_o    = hs_q;
  assign vsync_o    = vs_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan controller: raster timing, per-frame ball move strobe with pause/step,
// per-ball collision "empty" masks and registered RGB compositing.
module vga_scan_ctrl
  import vga_scan_ctrl_pkg::*;
#(
  parameter int unsigned N_BALLS  = 3,
  parameter int unsigned BORDER   = 8,
  parameter int unsigned MOVE_DIV = 1,
  parameter logic [11:0] BALL_RGB = 12'hFFF,
  parameter logic [11:0] WALL_RGB = 12'h00F,
  parameter int unsigned H_VIS    = VGA_H_VIS,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_VIS    = VGA_V_VIS,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pause_i,
  input  logic               step_i,
  input  logic [N_BALLS-1:0] draw_ball_i,
  output logic               pixpulse_o,
  output logic [CNT_W-1:0]   hcount_o,
  output logic [CNT_W-1:0]   vcount_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               move_o,
  output logic [N_BALLS-1:0] empty_o,
  output logic [11:0]        rgb_o
);

  localparam logic [CNT_W-1:0] H_VIS_C      = CNT_W'(H_VIS);
  localparam logic [CNT_W-1:0] V_VIS_C      = CNT_W'(V_VIS);
  localparam logic [CNT_W-1:0] H_LAST_C     = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST_C = CNT_W'(V_VIS - 1);
  localparam logic [CNT_W-1:0] V_LAST_C     = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] BORDER_C     = CNT_W'(BORDER);
  localparam logic [CNT_W-1:0] H_RWALL_C    = CNT_W'(H_VIS - BORDER);
  localparam logic [CNT_W-1:0] V_BWALL_C    = CNT_W'(V_VIS - BORDER);
  localparam logic [7:0]       FRAME_LAST_C = 8'(MOVE_DIV - 1);

  logic             pix;
  logic [CNT_W-1:0] hcnt, vcnt;

  vga_scan_ctrl_timing #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixpulse_o (pix),
    .hcount_o   (hcnt),
    .vcount_o   (vcnt),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o)
  );

  phase_e      phase_q, phase_d;
  logic [7:0]  frame_q, frame_d;
  logic        move_q, move_d;
  logic        step_pend_q, step_pend_d;
  logic [11:0] rgb_q, rgb_d;
  logic        line_end, vblank_entry, frame_end, move_end;
  logic        visible, wall;

  assign line_end     = pix && (hcnt == H_LAST_C);
  assign vblank_entry = line_end && (vcnt == V_VIS_LAST_C) && (phase_q == PH_ACTIVE);
  assign frame_end    = line_end && (vcnt == V_LAST_C);
  assign move_end     = move_q && pix;

  assign visible = (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
  assign wall    = visible && ((hcnt < BORDER_C) || (hcnt >= H_RWALL_C) ||
                               (vcnt < BORDER_C) || (vcnt >= V_BWALL_C));

  // The move strobe is raised on the edge that enters the first blanking pixel and
  // dropped by that pixel's own pixpulse, so exactly one pixpulse ever sees it.
  always_comb begin
    phase_d     = phase_q;
    frame_d     = frame_q;
    move_d      = move_q;
    step_pend_d = step_pend_q;
    rgb_d       = rgb_q;

    case (phase_q)
      PH_ACTIVE: if (vblank_entry) phase_d = PH_VBLANK;
      PH_VBLANK: if (frame_end)    phase_d = PH_ACTIVE;
    endcase

    if (vblank_entry)
      frame_d = (frame_q == FRAME_LAST_C) ? 8'd0 : frame_q + 8'd1;

    if (move_end)
      move_d = 1'b0;
    else if (vblank_entry && (frame_q == FRAME_LAST_C) && (!pause_i || step_pend_q))
      move_d = 1'b1;

    if (move_end)
      step_pend_d = 1'b0;
    else if (step_i && pause_i)
      step_pend_d = 1'b1;

    if (pix) begin
      if (!visible)          rgb_d = 12'h000;
      else if (|draw_ball_i) rgb_d = BALL_RGB;
      else if (wall)         rgb_d = WALL_RGB;
      else                   rgb_d = 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_ACTIVE;
      frame_q     <= 8'd0;
      move_q      <= 1'b0;
      step_pend_q <= 1'b0;
      rgb_q       <= 12'h000;
    end else begin
      phase_q     <= phase_d;
      frame_q     <= frame_d;
      move_q      <= move_d;
      step_pend_q <= step_pend_d;
      rgb_q       <= rgb_d;
    end
  end

  // A ball only counts the walls and the other balls as obstacles, never itself.
  for (genvar gi = 0; gi < N_BALLS; gi++) begin : g_empty
    localparam logic [N_BALLS-1:0] SELF = N_BALLS'(1) << gi;
    assign empty_o[gi] = ~visible | (~wall & ~|(draw_ball_i & ~SELF));
  end

  assign pixpulse_o = pix;
  assign hcount_o   = hcnt;
  assign vcount_o   = vcnt;
  assign move_o     = move_q;
  assign rgb_o      = rgb_q;

endmodule
